// File: rtl/lzd_arb_pkg.sv
// Shared types, constants and the round-robin picker for the lzd_scaler arbiter.
package lzd_arb_pkg;

   localparam int unsigned LZD_LATENCY = 2;
   // Upper bounds for the fixed-width package types; nreq must not exceed NREQ_MAX.
   localparam int unsigned NREQ_MAX = 16;
   localparam int unsigned NREQ_W = 4;
   localparam int unsigned IDBITS_MAX = 4;

   typedef struct packed {
      logic                  vld;
      logic [IDBITS_MAX-1:0] id;
   } lzd_arb_tag_t;

   // One-hot grant of the first valid requester at or above ptr, wrapping at n.
   function automatic logic [NREQ_MAX-1:0] rr_pick(input logic [NREQ_MAX-1:0] valid,
                                                   input int unsigned ptr,
                                                   input int unsigned n);
      logic [NREQ_MAX-1:0] g;
      logic found;
      int unsigned idx;
      g = '0;
      found = 1'b0;
      idx = 0;
      for (int unsigned off = 0; off < NREQ_MAX; off++) begin
         if (off < n && !found) begin
            idx = ptr + off;
            if (idx >= n) idx = idx - n;
            if (valid[idx[NREQ_W-1:0]]) begin
               g[idx[NREQ_W-1:0]] = 1'b1;
               found = 1'b1;
            end
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/lzd_scaler_arbiter_if.sv
// Request/response bundle between the requesters and the lzd_scaler arbiter.
interface lzd_scaler_arbiter_if #(
   parameter int unsigned nreq      = 4,
   parameter int unsigned idbits    = $clog2(nreq),
   parameter int unsigned ibits     = 22,
   parameter int unsigned shiftbits = $clog2(ibits)
);
   logic [nreq-1:0]            i_req_valid;
   logic [nreq-1:0][ibits-1:0] i_req_m;
   logic [nreq-1:0]            i_req_noscale;
   logic [nreq-1:0]            o_req_ready;
   logic                       o_resp_valid;
   logic [idbits-1:0]          o_resp_id;
   logic [ibits-1:0]           o_resp_scaled;
   logic [shiftbits-1:0]       o_resp_factor;
   logic                       o_busy;

   modport master (
      output i_req_valid, i_req_m, i_req_noscale,
      input  o_req_ready, o_resp_valid, o_resp_id, o_resp_scaled, o_resp_factor, o_busy
   );

   modport slave (
      input  i_req_valid, i_req_m, i_req_noscale,
      output o_req_ready, o_resp_valid, o_resp_id, o_resp_scaled, o_resp_factor, o_busy
   );
endinterface

// File: rtl/lzd_scaler.sv
// Two-stage normalizer: stage A counts leading zeros, stage B shifts the operand left.
module lzd_scaler #(
   parameter int unsigned ibits       = 22,
   parameter int unsigned shiftbits   = $clog2(ibits),
   parameter bit          async_reset = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_nrst,
   input  logic [ibits-1:0]     i_m,
   input  logic                 i_noscale,
   output logic [ibits-1:0]     o_scaled,
   output logic [shiftbits-1:0] o_factor
);
   logic [shiftbits-1:0] lz;
   logic [ibits-1:0]     a_m_d, a_m_q, b_scaled_d, b_scaled_q;
   logic [shiftbits-1:0] a_sh_d, a_sh_q, b_factor_d, b_factor_q;

   // Highest set bit wins; a zero operand yields 0.
   always_comb begin
      lz = '0;
      for (int i = 0; i < int'(ibits); i++) begin
         if (i_m[i]) lz = shiftbits'(int'(ibits) - 1 - i);
      end
   end

   always_comb begin
      a_m_d      = i_m;
      a_sh_d     = i_noscale ? '0 : lz;
      b_scaled_d = a_m_q << a_sh_q;
      b_factor_d = a_sh_q;
   end

   if (async_reset) begin : g_async
      always_ff @(posedge i_clk or negedge i_nrst) begin
         if (!i_nrst) begin
            a_m_q      <= '0;
            a_sh_q     <= '0;
            b_scaled_q <= '0;
            b_factor_q <= '0;
         end else begin
            a_m_q      <= a_m_d;
            a_sh_q     <= a_sh_d;
            b_scaled_q <= b_scaled_d;
            b_factor_q <= b_factor_d;
         end
      end
   end else begin : g_sync
      always_ff @(posedge i_clk) begin
         if (!i_nrst) begin
            a_m_q      <= '0;
            a_sh_q     <= '0;
            b_scaled_q <= '0;
            b_factor_q <= '0;
         end else begin
            a_m_q      <= a_m_d;
            a_sh_q     <= a_sh_d;
            b_scaled_q <= b_scaled_d;
            b_factor_q <= b_factor_d;
         end
      end
   end

   assign o_scaled = b_scaled_q;
   assign o_factor = b_factor_q;

endmodule

// File: rtl/lzd_scaler_arbiter.sv
// Round-robin arbiter sharing one lzd_scaler among nreq requesters, with an id tag pipe
// aligned to the scaler latency.
module lzd_scaler_arbiter
   import lzd_arb_pkg::*;
#(
   parameter int unsigned nreq      = 4,
   parameter int unsigned idbits    = $clog2(nreq),
   parameter int unsigned ibits     = 22,
   parameter int unsigned shiftbits = $clog2(ibits)
) (
   input  logic                 i_clk,
   input  logic                 i_nrst,
   lzd_scaler_arbiter_if.slave  bus
);
   logic [NREQ_MAX-1:0] pick;
   logic [nreq-1:0]     grant;
   logic [idbits-1:0]   grant_id;
   logic                accept;
   logic [idbits-1:0]   rr_ptr_d, rr_ptr_q;
   lzd_arb_tag_t [LZD_LATENCY-1:0] tag_d, tag_q;
   logic [ibits-1:0]    scl_m;
   logic                scl_noscale;
   logic                busy;

   always_comb begin
      pick     = rr_pick(NREQ_MAX'(bus.i_req_valid), 32'(rr_ptr_q), nreq);
      grant    = pick[nreq-1:0];
      accept   = |grant;
      grant_id = '0;
      for (int i = 0; i < int'(nreq); i++) begin
         if (grant[i]) grant_id = idbits'(i);
      end
   end

   assign bus.o_req_ready = i_nrst ? grant : '0;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (grant_id == idbits'(nreq - 1)) ? '0 : grant_id + idbits'(1);
      end
      tag_d[0] = '{vld: accept, id: IDBITS_MAX'(grant_id)};
      for (int unsigned i = 1; i < LZD_LATENCY; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         rr_ptr_q <= '0;
         tag_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         tag_q    <= tag_d;
      end
   end

   // Idle inputs are parked at zero/bypass so the scaler pipeline stays quiet.
   always_comb begin
      scl_m       = accept ? bus.i_req_m[grant_id] : '0;
      scl_noscale = accept ? bus.i_req_noscale[grant_id] : 1'b1;
   end

   lzd_scaler #(
      .ibits       (ibits),
      .shiftbits   (shiftbits),
      .async_reset (1'b1)
   ) u_scaler (
      .i_clk     (i_clk),
      .i_nrst    (i_nrst),
      .i_m       (scl_m),
      .i_noscale (scl_noscale),
      .o_scaled  (bus.o_resp_scaled),
      .o_factor  (bus.o_resp_factor)
   );

   always_comb begin
      busy = 1'b0;
      for (int unsigned i = 0; i < LZD_LATENCY; i++) begin
         busy = busy | tag_q[i].vld;
      end
   end

   assign bus.o_busy       = busy;
   assign bus.o_resp_valid = tag_q[LZD_LATENCY-1].vld;
   assign bus.o_resp_id    = tag_q[LZD_LATENCY-1].id[idbits-1:0];

endmodule
